// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage:
// FSM state encoding, default PC/NOP constants and address helpers.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] addr
    );
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC select: flush_pc, branch/jump target or pc+4, word-aligned.
// Ports: pc_plus4, pc_target, flush_pc, take_branch, flush in;
//        next_pc (aligned) and misaligned (source had addr[1:0]!=0) out.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int XLEN = fetch_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            take_branch,
    input  logic            flush,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        next_pc = pc_plus4;
        misaligned = 1'b0;
        if (flush) begin
            next_pc = {flush_pc[XLEN-1:2], 2'b00};
            misaligned = |flush_pc[1:0];
        end else if (take_branch) begin
            next_pc = {pc_target[XLEN-1:2], 2'b00};
            misaligned = |pc_target[1:0];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, requests words over a valid/ready imem port,
// presents one instruction at a time and redirects on retire or flush.
// Ports: clk/reset; imem_req_* / imem_resp_* memory side; instr_valid,
//        instr, pc, pc_plus4, instr_ready, PCSrc, pc_target to the
//        datapath; flush/flush_pc redirect; misaligned status pulse.
module instr_fetch_unit #(
    parameter int               XLEN      = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = fetch_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            instr_ready,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] pc_target,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic            misaligned
);

    import fetch_pkg::*;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic [31:0]     instr_reg;
    logic            drop_pending;
    logic            drop_nxt;
    logic            misaligned_q;
    logic            misaligned_nxt;
    logic            capture;
    logic            req_fire;
    logic            retire;
    logic [XLEN-1:0] sel_pc;
    logic            sel_misaligned;

    // A stale response still owed by memory blocks new requests so
    // that responses can never be paired with the wrong address.
    assign imem_req_valid = (state == REQ) && !drop_pending && !reset;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign retire         = (state == HOLD) && instr_ready;

    next_pc_sel #(
        .XLEN(XLEN)
    ) u_next_pc_sel (
        .pc_plus4   (pc_plus4_q),
        .pc_target  (pc_target),
        .flush_pc   (flush_pc),
        .take_branch(retire && PCSrc),
        .flush      (flush),
        .next_pc    (sel_pc),
        .misaligned (sel_misaligned)
    );

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        drop_nxt       = drop_pending;
        capture        = 1'b0;
        misaligned_nxt = sel_misaligned && (flush || retire);
        if (drop_pending && imem_resp_valid) begin
            drop_nxt = 1'b0;
        end
        if (flush) begin
            state_nxt    = REQ;
            fetch_pc_nxt = sel_pc;
            // A request is in flight (or just accepted) with no
            // response this cycle: its answer must be thrown away.
            if ((state == WAIT && !imem_resp_valid) || req_fire) begin
                drop_nxt = 1'b1;
            end
        end else begin
            unique case (state)
                REQ: begin
                    if (req_fire) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state_nxt = HOLD;
                        capture   = 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_nxt    = REQ;
                        fetch_pc_nxt = sel_pc;
                    end
                end
                default: begin
                    state_nxt = REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= REQ;
            fetch_pc     <= RESET_PC;
            drop_pending <= 1'b0;
            misaligned_q <= 1'b0;
            pc_q         <= RESET_PC;
            pc_plus4_q   <= RESET_PC + XLEN'(4);
            instr_reg    <= NOP_INSTR;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= fetch_pc_nxt;
            drop_pending <= drop_nxt;
            misaligned_q <= misaligned_nxt;
            if (req_fire) begin
                pc_q       <= fetch_pc;
                pc_plus4_q <= fetch_pc + XLEN'(4);
            end
            if (capture) begin
                instr_reg <= imem_resp_data;
            end
        end
    end

    assign instr_valid = (state == HOLD);
    assign instr       = instr_valid ? instr_reg : NOP_INSTR;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign misaligned  = misaligned_q;

endmodule
